// File: rtl/hmlf18_win_minmax_if.sv
// Sample-in / result-out bundle between the HMLF18 window feeder and its neighbours.
interface hmlf18_win_minmax_if #(
  parameter int W = 7
);
  logic                Flush;
  logic                InValid;
  logic signed [W-1:0] In;
  logic                OutValid;
  logic signed [W-1:0] Min;
  logic signed [W-1:0] Max;
  logic signed [W-1:0] Ctr;

  modport master (output Flush, InValid, In, input OutValid, Min, Max, Ctr);
  modport slave  (input Flush, InValid, In, output OutValid, Min, Max, Ctr);
endinterface

// File: rtl/hmlf18_win_minmax.sv
// 18-tap sliding window of signed samples reduced by a registered MIN/MAX tree;
// emits window min, max and the aligned centre tap five edges after acceptance.
module hmlf18_win_minmax #(
  parameter int N_TAP   = 18,
  parameter int W       = 7,
  parameter int CTR_IDX = 9
) (
  input logic                clk,
  input logic                rst,
  hmlf18_win_minmax_if.slave bus
);

  localparam int N1 = N_TAP / 2;
  localparam int N2 = (N1 + 1) / 2;
  localparam int N3 = (N2 + 1) / 2;
  localparam int N4 = (N3 + 1) / 2;
  localparam logic [4:0] CNT_MAX  = 5'(N_TAP);
  localparam logic [4:0] CNT_FULL = 5'(N_TAP - 1);

  typedef logic signed [W-1:0] samp_t;

  function automatic samp_t smin(input samp_t a, input samp_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic samp_t smax(input samp_t a, input samp_t b);
    return (a > b) ? a : b;
  endfunction

  samp_t      tap_q [N_TAP];
  logic [4:0] cnt_q;
  logic [4:0] vld_q;
  samp_t      ctr_pipe_q [4];
  samp_t      l1_min_q [N1], l1_max_q [N1], l1_min_d [N1], l1_max_d [N1];
  samp_t      l2_min_q [N2], l2_max_q [N2], l2_min_d [N2], l2_max_d [N2];
  samp_t      l3_min_q [N3], l3_max_q [N3], l3_min_d [N3], l3_max_d [N3];
  samp_t      l4_min_q [N4], l4_max_q [N4], l4_min_d [N4], l4_max_d [N4];
  samp_t      min_q, max_q, ctr_q;
  logic       out_valid_q;

  for (genvar gi = 0; gi < N1; gi++) begin : g_l1
    assign l1_min_d[gi] = smin(tap_q[2*gi], tap_q[2*gi+1]);
    assign l1_max_d[gi] = smax(tap_q[2*gi], tap_q[2*gi+1]);
  end

  // Odd leftover element at each level is registered unchanged so both trees stay aligned.
  for (genvar gi = 0; gi < N2; gi++) begin : g_l2
    if (2*gi + 1 < N1) begin : g_pair
      assign l2_min_d[gi] = smin(l1_min_q[2*gi], l1_min_q[2*gi+1]);
      assign l2_max_d[gi] = smax(l1_max_q[2*gi], l1_max_q[2*gi+1]);
    end else begin : g_pass
      assign l2_min_d[gi] = l1_min_q[2*gi];
      assign l2_max_d[gi] = l1_max_q[2*gi];
    end
  end

  for (genvar gi = 0; gi < N3; gi++) begin : g_l3
    if (2*gi + 1 < N2) begin : g_pair
      assign l3_min_d[gi] = smin(l2_min_q[2*gi], l2_min_q[2*gi+1]);
      assign l3_max_d[gi] = smax(l2_max_q[2*gi], l2_max_q[2*gi+1]);
    end else begin : g_pass
      assign l3_min_d[gi] = l2_min_q[2*gi];
      assign l3_max_d[gi] = l2_max_q[2*gi];
    end
  end

  for (genvar gi = 0; gi < N4; gi++) begin : g_l4
    if (2*gi + 1 < N3) begin : g_pair
      assign l4_min_d[gi] = smin(l3_min_q[2*gi], l3_min_q[2*gi+1]);
      assign l4_max_d[gi] = smax(l3_max_q[2*gi], l3_max_q[2*gi+1]);
    end else begin : g_pass
      assign l4_min_d[gi] = l3_min_q[2*gi];
      assign l4_max_d[gi] = l3_max_q[2*gi];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.Flush) begin
      tap_q       <= '{default: '0};
      cnt_q       <= '0;
      vld_q       <= '0;
      ctr_pipe_q  <= '{default: '0};
      l1_min_q    <= '{default: '0};
      l1_max_q    <= '{default: '0};
      l2_min_q    <= '{default: '0};
      l2_max_q    <= '{default: '0};
      l3_min_q    <= '{default: '0};
      l3_max_q    <= '{default: '0};
      l4_min_q    <= '{default: '0};
      l4_max_q    <= '{default: '0};
      min_q       <= '0;
      max_q       <= '0;
      ctr_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (bus.InValid) begin
        tap_q[0] <= bus.In;
        for (int i = 1; i < N_TAP; i++) tap_q[i] <= tap_q[i-1];
        if (cnt_q < CNT_MAX) cnt_q <= cnt_q + 5'd1;
      end
      // Tag launched with the window update, then rides beside L1..L4.
      vld_q         <= {vld_q[3:0], bus.InValid && (cnt_q >= CNT_FULL)};
      l1_min_q      <= l1_min_d;
      l1_max_q      <= l1_max_d;
      l2_min_q      <= l2_min_d;
      l2_max_q      <= l2_max_d;
      l3_min_q      <= l3_min_d;
      l3_max_q      <= l3_max_d;
      l4_min_q      <= l4_min_d;
      l4_max_q      <= l4_max_d;
      ctr_pipe_q[0] <= tap_q[CTR_IDX];
      for (int i = 1; i < 4; i++) ctr_pipe_q[i] <= ctr_pipe_q[i-1];
      // Final level doubles as the output register and holds between valid results.
      if (vld_q[4]) begin
        min_q <= smin(l4_min_q[0], l4_min_q[1]);
        max_q <= smax(l4_max_q[0], l4_max_q[1]);
        ctr_q <= ctr_pipe_q[3];
      end
      out_valid_q <= vld_q[4];
    end
  end

  assign bus.OutValid = out_valid_q;
  assign bus.Min      = min_q;
  assign bus.Max      = max_q;
  assign bus.Ctr      = ctr_q;

endmodule
